// File: rtl/param_seq_datapath_pkg.sv
// Shared ALU op codes, select-vector offsets and sequencer state encoding
// for the bus-based datapath and its iterative multiply/divide unit.
package param_seq_datapath_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_SHR = 4'd4,
        OP_SHL = 4'd5,
        OP_ROR = 4'd6,
        OP_ROL = 4'd7,
        OP_NEG = 4'd8,
        OP_NOT = 4'd9,
        OP_MUL = 4'd10,
        OP_DIV = 4'd11
    } alu_op_e;

    // Offsets above R0..R(NUM_REGS-1) inside in_sel / out_sel.
    localparam int IDX_PC      = 0;
    localparam int IDX_HI      = 1;
    localparam int IDX_LO      = 2;
    localparam int IDX_Y_IN    = 3;
    localparam int IDX_MDR_IN  = 4;
    localparam int IN_EXTRA    = 5;
    localparam int IDX_ZHI_OUT = 3;
    localparam int IDX_ZLO_OUT = 4;
    localparam int IDX_MDR_OUT = 5;
    localparam int OUT_EXTRA   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } seq_state_e;

    function automatic logic is_single_op(input logic [3:0] op);
        return op <= OP_NOT;
    endfunction

endpackage

// File: rtl/param_seq_datapath_iter_muldiv.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring on magnitudes)
// sequencer. start must only be raised for a MUL/DIV while idle.
module param_seq_datapath_iter_muldiv
    import param_seq_datapath_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              fin,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              div0,
    output seq_state_e        state
);
    localparam int CW = $clog2(DATA_W);

    logic              is_mul;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     last_cnt;
    logic [DATA_W:0]   acc;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] m;
    logic              q_1;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W:0]   m_ext;
    logic [DATA_W:0]   b_sum;
    logic [DATA_W:0]   b_acc;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W:0]   d_shl;
    logic [DATA_W:0]   d_diff;
    logic [DATA_W:0]   d_acc;
    logic [DATA_W-1:0] d_q;

    assign div0  = start && (op == OP_DIV) && (b == '0);
    assign busy  = (state != ST_IDLE);
    assign fin   = (state == ST_FIN);
    assign mag_a = a[DATA_W-1] ? -a : a;
    assign mag_b = b[DATA_W-1] ? -b : b;
    // MUL keeps its final Booth step for FIN; DIV uses FIN for the sign fix.
    assign last_cnt = is_mul ? CW'(1) : '0;

    always_comb begin
        m_ext = {m[DATA_W-1], m};
        case ({q[0], q_1})
            2'b01:   b_sum = acc + m_ext;
            2'b10:   b_sum = acc - m_ext;
            default: b_sum = acc;
        endcase
        b_acc  = {b_sum[DATA_W], b_sum[DATA_W:1]};
        b_q    = {b_sum[0], q[DATA_W-1:1]};
        d_shl  = {acc[DATA_W-1:0], q[DATA_W-1]};
        d_diff = d_shl - {1'b0, m};
        if (d_diff[DATA_W]) begin
            d_acc = d_shl;
            d_q   = {q[DATA_W-2:0], 1'b0};
        end else begin
            d_acc = d_diff;
            d_q   = {q[DATA_W-2:0], 1'b1};
        end
    end

    always_comb begin
        if (is_mul) begin
            hi = b_acc[DATA_W-1:0];
            lo = b_q;
        end else begin
            lo = (a_neg ^ b_neg) ? -q : q;
            hi = a_neg ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
        end
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            is_mul <= 1'b0;
            acc    <= '0;
            q      <= '0;
            m      <= '0;
            q_1    <= 1'b0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !div0) begin
                        is_mul <= (op == OP_MUL);
                        cnt    <= CW'(DATA_W - 1);
                        acc    <= '0;
                        q_1    <= 1'b0;
                        q      <= (op == OP_MUL) ? b : mag_a;
                        m      <= (op == OP_MUL) ? a : mag_b;
                        a_neg  <= a[DATA_W-1];
                        b_neg  <= b[DATA_W-1];
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (is_mul) begin
                        acc <= b_acc;
                        q   <= b_q;
                        q_1 <= q[0];
                    end else begin
                        acc <= d_acc;
                        q   <= d_q;
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == last_cnt) state <= ST_FIN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/param_seq_datapath.sv
// Shared-bus CPU datapath: general registers, PC/HI/LO/Y/MDR, Z pair written by a
// single-cycle ALU or by the iterative multiply/divide sequencer.
module param_seq_datapath
    import param_seq_datapath_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 16,
    parameter int MULDIV_EN = 1
) (
    input  logic                          Clock,
    input  logic                          Clear,
    input  logic [NUM_REGS+IN_EXTRA-1:0]  in_sel,
    input  logic [NUM_REGS+OUT_EXTRA-1:0] out_sel,
    input  logic                          Read,
    input  logic [DATA_W-1:0]             Mdatain,
    input  logic [3:0]                    alu_op,
    input  logic                          alu_start,
    output logic                          alu_busy,
    output logic                          alu_done,
    output logic                          op_err,
    output logic                          bus_err,
    output logic [DATA_W-1:0]             BusMuxOut,
    output logic [DATA_W-1:0]             MDRdata,
    output seq_state_e                    dbg_state
);
    localparam int OW = NUM_REGS + OUT_EXTRA;
    localparam int SW = $clog2(DATA_W);
    localparam bit MD = (MULDIV_EN != 0);

    logic [DATA_W-1:0] gpr [NUM_REGS];
    logic [DATA_W-1:0] src [OW];
    logic [DATA_W-1:0] pc, hi, lo, y, mdr, zhi, zlo;
    logic [DATA_W-1:0] bus, bus_or, alu_res, md_hi, md_lo;
    logic [SW-1:0]     amt;
    logic [SW:0]       inv_amt;
    logic              accept, single_go, md_go, illegal_go;
    logic              md_busy, md_fin, div0;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_gpr
        logic [DATA_W-1:0] r;
        always_ff @(posedge Clock or posedge Clear) begin
            if (Clear) r <= '0;
            else if (in_sel[g]) r <= bus;
        end
        assign gpr[g] = r;
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            pc  <= '0;
            hi  <= '0;
            lo  <= '0;
            y   <= '0;
            mdr <= '0;
        end else begin
            if (in_sel[NUM_REGS+IDX_PC])     pc  <= bus;
            if (in_sel[NUM_REGS+IDX_HI])     hi  <= bus;
            if (in_sel[NUM_REGS+IDX_LO])     lo  <= bus;
            if (in_sel[NUM_REGS+IDX_Y_IN])   y   <= bus;
            if (in_sel[NUM_REGS+IDX_MDR_IN]) mdr <= Read ? Mdatain : bus;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) src[i] = gpr[i];
        src[NUM_REGS+IDX_PC]      = pc;
        src[NUM_REGS+IDX_HI]      = hi;
        src[NUM_REGS+IDX_LO]      = lo;
        src[NUM_REGS+IDX_ZHI_OUT] = zhi;
        src[NUM_REGS+IDX_ZLO_OUT] = zlo;
        src[NUM_REGS+IDX_MDR_OUT] = mdr;
    end

    // A multi-hot select is a control fault: flag it and keep the bus quiet.
    always_comb begin
        bus_or = '0;
        for (int i = 0; i < OW; i++) if (out_sel[i]) bus_or = bus_or | src[i];
    end
    assign bus_err   = |(out_sel & (out_sel - OW'(1)));
    assign bus       = bus_err ? '0 : bus_or;
    assign BusMuxOut = bus;
    assign MDRdata   = mdr;

    assign amt     = bus[SW-1:0];
    assign inv_amt = (SW+1)'(DATA_W) - {1'b0, amt};

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = y + bus;
            OP_SUB:  alu_res = y - bus;
            OP_AND:  alu_res = y & bus;
            OP_OR:   alu_res = y | bus;
            OP_SHR:  alu_res = y >> amt;
            OP_SHL:  alu_res = y << amt;
            OP_ROR:  alu_res = (y >> amt) | (y << inv_amt);
            OP_ROL:  alu_res = (y << amt) | (y >> inv_amt);
            OP_NEG:  alu_res = -bus;
            OP_NOT:  alu_res = ~bus;
            default: alu_res = '0;
        endcase
    end

    assign accept     = alu_start && !md_busy;
    assign single_go  = accept && is_single_op(alu_op);
    assign md_go      = accept && MD && ((alu_op == OP_MUL) || (alu_op == OP_DIV));
    assign illegal_go = accept && !is_single_op(alu_op) && !md_go;
    assign alu_busy   = md_busy;

    param_seq_datapath_iter_muldiv #(.DATA_W(DATA_W)) u_iter_muldiv (
        .Clock (Clock),
        .Clear (Clear),
        .start (md_go),
        .op    (alu_op),
        .a     (y),
        .b     (bus),
        .busy  (md_busy),
        .fin   (md_fin),
        .hi    (md_hi),
        .lo    (md_lo),
        .div0  (div0),
        .state (dbg_state)
    );

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            zhi      <= '0;
            zlo      <= '0;
            alu_done <= 1'b0;
            op_err   <= 1'b0;
        end else begin
            if (single_go) begin
                zlo <= alu_res;
                zhi <= '0;
            end else if (div0) begin
                zlo <= '1;
                zhi <= y;
            end else if (md_fin) begin
                zhi <= md_hi;
                zlo <= md_lo;
            end
            alu_done <= single_go | div0 | illegal_go | md_fin;
            op_err   <= div0 | illegal_go;
        end
    end

endmodule

// File: tb/tb_param_seq_datapath.sv
// Directed bench for param_seq_datapath (DATA_W=32, NUM_REGS=16) with
// hand-computed expectations checked by immediate assertions.
module tb_param_seq_datapath;
    import param_seq_datapath_pkg::*;

    localparam int W     = 32;
    localparam int N     = 16;
    localparam int IW    = N + IN_EXTRA;
    localparam int OW    = N + OUT_EXTRA;
    localparam int I_Y   = N + IDX_Y_IN;
    localparam int I_MDR = N + IDX_MDR_IN;
    localparam int O_ZHI = N + IDX_ZHI_OUT;
    localparam int O_ZLO = N + IDX_ZLO_OUT;
    localparam int O_MDR = N + IDX_MDR_OUT;

    logic          Clock, Clear, Read, alu_start;
    logic          alu_busy, alu_done, op_err, bus_err;
    logic [IW-1:0] in_sel;
    logic [OW-1:0] out_sel;
    logic [W-1:0]  Mdatain, BusMuxOut, MDRdata;
    logic [3:0]    alu_op;
    seq_state_e    dbg_state;

    int total = 0;
    int bad   = 0;
    int n;
    int dones;

    logic [3:0]   ops  [10] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
                                OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT};
    logic [W-1:0] exps [10] = '{32'h80000025, 32'h7FFFFFDD, 32'h00000000, 32'h80000025,
                                32'h08000000, 32'h00000010, 32'h18000000, 32'h00000018,
                                32'hFFFFFFDC, 32'hFFFFFFDB};

    param_seq_datapath #(.DATA_W(W), .NUM_REGS(N), .MULDIV_EN(1)) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .in_sel    (in_sel),
        .out_sel   (out_sel),
        .Read      (Read),
        .Mdatain   (Mdatain),
        .alu_op    (alu_op),
        .alu_start (alu_start),
        .alu_busy  (alu_busy),
        .alu_done  (alu_done),
        .op_err    (op_err),
        .bus_err   (bus_err),
        .BusMuxOut (BusMuxOut),
        .MDRdata   (MDRdata),
        .dbg_state (dbg_state)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_sel    = '0;
        out_sel   = '0;
        Read      = 1'b0;
        alu_start = 1'b0;
        alu_op    = '0;
        Mdatain   = '0;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input int idx, input logic [W-1:0] v);
        Read    = 1'b1;
        Mdatain = v;
        in_sel  = IW'(1) << I_MDR;
        step();
        idle();
        out_sel = OW'(1) << O_MDR;
        in_sel  = IW'(1) << idx;
        step();
        idle();
    endtask

    task automatic check_bus(input string tag, input int osel, input logic [W-1:0] exp);
        out_sel = OW'(1) << osel;
        #1;
        chk(tag, BusMuxOut, exp);
        out_sel = '0;
    endtask

    task automatic alu(input logic [3:0] op, input int bsrc);
        out_sel   = OW'(1) << bsrc;
        alu_op    = op;
        alu_start = 1'b1;
        step();
        idle();
    endtask

    task automatic wait_idle();
        n     = 0;
        dones = 0;
        while (alu_busy && n < 100) begin
            step();
            n++;
            if (alu_done) dones++;
        end
    endtask

    initial begin
        Clear = 1'b1;
        idle();
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_busy", alu_busy, 0);
        chk("reset_done", alu_done, 0);
        chk("reset_err", op_err, 0);
        chk("reset_state", dbg_state, ST_IDLE);
        Clear = 1'b0;
        step();
        check_bus("reset_zlo", O_ZLO, 0);
        check_bus("reset_r3", 3, 0);
        #1;
        chk("zero_hot_bus", BusMuxOut, 0);
        chk("zero_hot_err", bus_err, 0);

        // R3=7 via MDR, R3 -> Y, R4=5, then ADD
        load(3, 32'd7);
        out_sel = OW'(1) << 3;
        in_sel  = IW'(1) << I_Y;
        step();
        idle();
        load(4, 32'd5);
        chk("mdr_data", MDRdata, 5);
        alu(OP_ADD, 4);
        chk("add_done", alu_done, 1);
        chk("add_err", op_err, 0);
        check_bus("add_zlo", O_ZLO, 12);
        check_bus("add_zhi", O_ZHI, 0);
        step();
        chk("add_done_pulse", alu_done, 0);

        // -6 * 7
        load(I_Y, 32'hFFFFFFFA);
        load(4, 32'd7);
        alu(OP_MUL, 4);
        chk("mul_busy", alu_busy, 1);
        chk("mul_state", dbg_state, ST_RUN);
        wait_idle();
        chk("mul_cycles", n, 32);
        chk("mul_done_count", dones, 1);
        chk("mul_done_end", alu_done, 1);
        check_bus("mul_zhi", O_ZHI, 32'hFFFFFFFF);
        check_bus("mul_zlo", O_ZLO, 32'hFFFFFFD6);
        step();
        chk("mul_done_once", alu_done, 0);

        // -17 / 5 with a start re-pulsed mid-operation
        load(I_Y, 32'hFFFFFFEF);
        load(4, 32'd5);
        alu(OP_DIV, 4);
        n     = 0;
        dones = 0;
        while (alu_busy && n < 100) begin
            if (n == 10) begin
                alu_op    = OP_ADD;
                out_sel   = OW'(1) << 4;
                alu_start = 1'b1;
            end else begin
                idle();
            end
            step();
            n++;
            if (alu_done) dones++;
        end
        idle();
        chk("div_cycles", n, 33);
        chk("div_done_count", dones, 1);
        chk("div_err", op_err, 0);
        check_bus("div_zlo", O_ZLO, 32'hFFFFFFFD);
        check_bus("div_zhi", O_ZHI, 32'hFFFFFFFE);
        step();
        chk("div_done_once", alu_done, 0);

        // 9 / 0 (R0 is still zero)
        load(I_Y, 32'd9);
        alu(OP_DIV, 0);
        chk("div0_busy", alu_busy, 0);
        chk("div0_done", alu_done, 1);
        chk("div0_err", op_err, 1);
        check_bus("div0_zlo", O_ZLO, 32'hFFFFFFFF);
        check_bus("div0_zhi", O_ZHI, 32'd9);
        step();
        chk("div0_err_pulse", op_err, 0);

        // Z read on the bus in the same cycle the ALU writes Z
        out_sel   = OW'(1) << O_ZLO;
        alu_op    = OP_ADD;
        alu_start = 1'b1;
        #1;
        chk("z_old_on_bus", BusMuxOut, 32'hFFFFFFFF);
        step();
        idle();
        check_bus("add_wrap_zlo", O_ZLO, 32'd8);
        check_bus("add_wrap_zhi", O_ZHI, 0);

        // Single-cycle ops, shift amount taken from B[4:0] of 0x24
        load(I_Y, 32'h80000001);
        load(4, 32'h00000024);
        for (int k = 0; k < 10; k++) begin
            alu(ops[k], 4);
            chk($sformatf("op%0d_done", k), alu_done, 1);
            check_bus($sformatf("op%0d_zlo", k), O_ZLO, exps[k]);
        end

        // Undefined op code
        alu(4'd12, 4);
        chk("illegal_done", alu_done, 1);
        chk("illegal_err", op_err, 1);
        check_bus("illegal_zlo", O_ZLO, 32'hFFFFFFDB);
        step();
        chk("illegal_err_pulse", op_err, 0);

        // Clear in the middle of a MUL, then a fresh MUL
        load(I_Y, 32'd123);
        load(4, 32'hFFFFFFFE);
        alu(OP_MUL, 4);
        repeat (9) step();
        Clear = 1'b1;
        #1;
        chk("clr_busy", alu_busy, 0);
        chk("clr_state", dbg_state, ST_IDLE);
        check_bus("clr_zlo", O_ZLO, 0);
        #1;
        Clear = 1'b0;
        step();
        chk("clr_no_done", alu_done, 0);
        load(I_Y, 32'd1000);
        load(4, 32'hFFFFFFFD);
        alu(OP_MUL, 4);
        wait_idle();
        chk("mul2_cycles", n, 32);
        check_bus("mul2_zhi", O_ZHI, 32'hFFFFFFFF);
        check_bus("mul2_zlo", O_ZLO, 32'hFFFFF448);

        // Multi-hot bus select, then read+write of the same register
        load(1, 32'h11);
        load(2, 32'h22);
        out_sel = (OW'(1) << 1) | (OW'(1) << 2);
        #1;
        chk("multi_bus", BusMuxOut, 0);
        chk("multi_err", bus_err, 1);
        out_sel = OW'(1) << 1;
        #1;
        chk("r1_bus", BusMuxOut, 32'h11);
        chk("r1_err", bus_err, 0);
        out_sel = '0;
        load(5, 32'hA5);
        out_sel = OW'(1) << 5;
        in_sel  = IW'(1) << 5;
        #1;
        chk("r5_rw_bus", BusMuxOut, 32'hA5);
        step();
        idle();
        check_bus("r5_hold", 5, 32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
